// File: rtl/adder16b_pkg.sv
// adder16b_pkg: shared width constants and word type for the 16-bit adder
package adder16b_pkg;
  localparam int ADD_WIDTH = 16;
  localparam int CLA_BLK = 4;
  typedef logic [ADD_WIDTH-1:0] word_t;
endpackage

// File: rtl/adder_16b_if.sv
// adder_16b_if: operand/result bundle for adder_16b
//   master: drives in_valid, a, b, ci; receives r, co, out_valid (and ovf with ADDER_OVF_EN)
//   slave : the adder side of the same signals
interface adder_16b_if import adder16b_pkg::*; #(parameter int WIDTH = ADD_WIDTH);
  logic in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic ci;
  logic [WIDTH-1:0] r;
  logic co;
  logic out_valid;
`ifdef ADDER_OVF_EN
  logic ovf;
  modport master(output in_valid, a, b, ci, input r, co, out_valid, ovf);
  modport slave(input in_valid, a, b, ci, output r, co, out_valid, ovf);
`else
  modport master(output in_valid, a, b, ci, input r, co, out_valid);
  modport slave(input in_valid, a, b, ci, output r, co, out_valid);
`endif
endinterface

// File: rtl/adder_16b_cla4.sv
// cla4: 4-bit carry-lookahead slice
//   a, b, cin -> s (sum), cout, p (group propagate), g (group generate)
module cla4 import adder16b_pkg::*; (
  input  logic [CLA_BLK-1:0] a,
  input  logic [CLA_BLK-1:0] b,
  input  logic               cin,
  output logic [CLA_BLK-1:0] s,
  output logic               cout,
  output logic               p,
  output logic               g
);
  logic [CLA_BLK-1:0] pi, gi, c;
  assign pi = a ^ b;
  assign gi = a & b;
  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & cin);
  assign s = pi ^ c;
  assign p = &pi;
  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign cout = g | (p & cin);
endmodule

// File: rtl/adder_16b.sv
// adder_16b: registered WIDTH-bit adder {co,r} = a + b + ci, one cycle latency
//   clk, rst_n (async active-low), bus (adder_16b_if.slave: in_valid, a, b, ci -> r, co, out_valid)
//   Optional: define ADDER_OVF_EN to add the registered signed-overflow output bus.ovf
module adder_16b import adder16b_pkg::*; #(parameter int WIDTH = ADD_WIDTH) (
  input logic clk,
  input logic rst_n,
  adder_16b_if.slave bus
);
  localparam int N = WIDTH / CLA_BLK;
  logic [WIDTH-1:0] s;
  logic [N:0] c;
  logic [N-1:0] p_grp, g_grp;
  logic la;
  assign c[0] = bus.ci;
  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_slice
      cla4 u_cla (
        .a(bus.a[CLA_BLK*i +: CLA_BLK]),
        .b(bus.b[CLA_BLK*i +: CLA_BLK]),
        .cin(c[i]),
        .s(s[CLA_BLK*i +: CLA_BLK]),
        .cout(c[i+1]),
        .p(p_grp[i]),
        .g(g_grp[i])
      );
    end
  endgenerate
  // Carry-out resolved from the slice P/G terms; equal to the rippled c[N], merged so both carry views feed the result.
  always_comb begin
    la = bus.ci;
    for (int k = 0; k < N; k++) la = g_grp[k] | (p_grp[k] & la);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.r <= '0;
      bus.co <= 1'b0;
      bus.out_valid <= 1'b0;
`ifdef ADDER_OVF_EN
      bus.ovf <= 1'b0;
`endif
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.r <= s;
        bus.co <= c[N] | la;
`ifdef ADDER_OVF_EN
        bus.ovf <= (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (s[WIDTH-1] != bus.a[WIDTH-1]);
`endif
      end
    end
  end
endmodule

// File: tb/tb_adder_16b.sv
// tb_adder_16b: scoreboard bench for adder_16b against an integer-arithmetic model
module tb_adder_16b;
  import adder16b_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  adder_16b_if bus();
  adder_16b dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic v;
    word_t r;
    logic co;
    logic ovf;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int fails = 0;
  word_t m_r = '0;
  logic m_co = 1'b0;
  logic m_ovf = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(logic v, word_t a, word_t b, logic ci);
    exp_t e;
    int sum, sa;
    @(negedge clk);
    bus.in_valid = v;
    bus.a = a;
    bus.b = b;
    bus.ci = ci;
    if (v) begin
      sum = int'(a) + int'(b) + int'(ci);
      m_r = word_t'(sum % 65536);
      m_co = sum >= 65536;
      sa = int'($signed(a)) + int'($signed(b)) + int'(ci);
      m_ovf = (sa > 32767) || (sa < -32768);
    end
    e = '{v, m_r, m_co, m_ovf};
    q.push_back(e);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_valid", 32'(bus.out_valid), 32'(e.v));
      chk("r", 32'(bus.r), 32'(e.r));
      chk("co", 32'(bus.co), 32'(e.co));
`ifdef ADDER_OVF_EN
      chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
    end else begin
      chk("idle out_valid", 32'(bus.out_valid), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.ci = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset r", 32'(bus.r), 32'd0);
    chk("reset co", 32'(bus.co), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 16'd50, 16'd100, 1'b0);
    step(1'b1, 16'd500, 16'd100, 1'b0);
    step(1'b1, 16'd500, 16'd0, 1'b0);
    step(1'b1, 16'd40000, 16'd0, 1'b0);
    step(1'b1, 16'd40000, 16'd0, 1'b1);
    step(1'b1, 16'd0, 16'd0, 1'b1);
    step(1'b1, 16'd40000, 16'd40000, 1'b1);
    step(1'b1, 16'd2000, 16'd40000, 1'b1);
    step(1'b0, 16'd1234, 16'd4321, 1'b0);
    step(1'b0, 16'd9999, 16'd7777, 1'b1);
    step(1'b1, 16'hFFFF, 16'd0, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step(1'b1, 16'h7FFF, 16'd1, 1'b0);
    step(1'b1, 16'h8000, 16'h8000, 1'b0);
    step(1'b1, 16'd50, 16'd100, 1'b0);
    step(1'b1, 16'd40000, 16'd40000, 1'b1);
    step(1'b1, 16'd1, 16'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    m_r = '0;
    m_co = 1'b0;
    m_ovf = 1'b0;
    #1;
    chk("async reset r", 32'(bus.r), 32'd0);
    chk("async reset co", 32'(bus.co), 32'd0);
    chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 16'd50, 16'd100, 1'b0);
    step(1'b0, 16'd3, 16'd4, 1'b1);
    repeat (300) step($urandom_range(0, 3) != 0, word_t'($urandom), word_t'($urandom), 1'($urandom_range(0, 1)));
    step(1'b0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
